search_monitor: RTL
===================

Name: search_monitor

Overview:
- Synthesisable protocol monitor and statistics block for the search RAM engine. Parametrised successor to the passive search monitor.
- Taps the engine's search request and hit-result interfaces and pairs every hit_vd_i with its originating key through an in-order tracking FIFO.
- Measures per-search latency, keeps saturating hit/miss counters and flags protocol violations as sticky error bits.
- Sits beside the engine in both the test bench and the on-chip debug path.

Parameters:
- C_NUM_TABLE, 4, number of block RAMs (1, 2, 4, 8 or 16).
- C_RULE_WIDTH, 24, key/rule bit width.
- C_MEM_DATA_WIDTH, 56, RAM word width; hit data width is C_MEM_DATA_WIDTH-C_RULE_WIDTH.
- C_MEM_ADDR_WIDTH, 8, RAM address width.
- C_MAX_OUTST, 4, maximum outstanding searches (power of 2, 2..16).
- C_TIMEOUT, 64, cycles after which an unanswered search is late.
- C_CNT_WIDTH, 32, statistics counter width.
- C_LAT_WIDTH, 16, timestamp/latency width.

Ports:
- clk_i  in  1  single clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous clear of counters, lat_max_o and err_o.
- search_i  in  1  search strobe.
- key_i  in  C_RULE_WIDTH  searched key.
- ready_i  in  C_NUM_TABLE  per-table ready.
- busy_i  in  C_NUM_TABLE  per-table busy.
- hit_vd_i  in  1  result strobe.
- hit_i  in  1  1 = found, 0 = miss.
- hit_tab_i  in  4  table index of the hit.
- hit_addr_i  in  C_MEM_ADDR_WIDTH  hit address.
- hit_data_i  in  C_MEM_DATA_WIDTH-C_RULE_WIDTH  hit data.
- mon_vd_o  out  1  paired-result strobe.
- mon_key_o  out  C_RULE_WIDTH  key belonging to the result.
- mon_hit_o  out  1  registered hit_i.
- mon_tab_o  out  4  registered hit_tab_i.
- mon_lat_o  out  C_LAT_WIDTH  latency of this search in cycles.
- lat_max_o  out  C_LAT_WIDTH  maximum latency since reset or clear.
- search_cnt_o  out  C_CNT_WIDTH  accepted searches.
- hit_cnt_o  out  C_CNT_WIDTH  results with hit.
- miss_cnt_o  out  C_CNT_WIDTH  results without hit.
- outst_o  out  $clog2(C_MAX_OUTST)+1  current FIFO occupancy.
- err_o  out  5  sticky errors: [0] overflow, [1] spurious, [2] not_ready, [3] bad_tab, [4] timeout.

Behaviour:
- Reset: every output and register is 0, the FIFO is empty and the head FSM is in H_EMPTY. Reset mid-operation discards all outstanding entries.
- Free-running timestamp counter ts, C_LAT_WIDTH bits, wraps modulo 2^C_LAT_WIDTH.
- Push:
  - search_i=1 and FIFO not full: push {key_i, ts} and increment search_cnt.
  - search_i=1 and FIFO full: no push, search_cnt unchanged, set err[0].
- search_i=1 while ready_i is not all-ones or busy_i is non-zero: set err[2]. The entry is still pushed.
- Pop:
  - hit_vd_i=1 with the FIFO non-empty at the start of the cycle pops the head.
  - One cycle later: mon_vd_o=1, mon_key_o=head key, mon_lat_o=(ts-head_ts) mod 2^C_LAT_WIDTH, and mon_hit_o/mon_tab_o carry the registered inputs.
  - mon_key_o, mon_hit_o, mon_tab_o and mon_lat_o hold their values until the next mon_vd_o.
- hit_vd_i=1 with the FIFO empty at the start of the cycle: set err[1], no pop, no mon_vd_o. This applies even if search_i=1 in the same cycle; minimum legal latency is 1 cycle.
- Simultaneous push and pop on a non-empty FIFO: both occur and occupancy is unchanged. When full, the pop frees no slot in the same cycle, so the push is an overflow.
- hit_vd_i=1 and hit_i=1 with hit_tab_i >= C_NUM_TABLE: set err[3]. The result is still paired and counted.
- hit_cnt or miss_cnt increments on every paired result. lat_max updates when mon_lat_o exceeds it. All counters saturate at all-ones.
- Head FSM:
  - H_EMPTY -> H_WAIT when the FIFO becomes non-empty.
  - H_WAIT -> H_LATE when (ts-head_ts) >= C_TIMEOUT; err[4] is set once on this transition.
  - H_WAIT or H_LATE -> H_WAIT on pop if entries remain, otherwise -> H_EMPTY. On pop the age is re-evaluated against the new head.
  - H_LATE stays in H_LATE until the pop; the entry is not discarded.
- clr_i=1: on the next edge zero the counters, lat_max and err. The FIFO, ts and FSM are untouched. If clr_i coincides with an event, clear wins, and a newly detected error in that cycle is still set.

Decomposition:
- Package search_mon_pkg:
  - ERR_OVF..ERR_TMO bit indices and ERR_W=5.
  - Head-state enum h_state_t (H_EMPTY, H_WAIT, H_LATE).
  - Saturating-increment function.
- Sub-module search_mon_fifo: parametrised synchronous FIFO (width, depth), with full/empty/count, and simultaneous push/pop supported.

Test Plan:
- Search key 24'hA5A5A5, hit_vd_i 5 cycles later with hit_i=1, hit_tab_i=2 -> mon_vd_o one cycle after hit_vd_i, key A5A5A5, lat 5, hit_cnt=1, err_o=0.
- Four back-to-back searches with keys 1..4, then four results with hit_i=1,0,1,0 -> keys paired in order 1..4, hit_cnt=2, miss_cnt=2, outst_o returns to 0.
- Five searches with no results, C_MAX_OUTST=4 -> err_o[0]=1, search_cnt=4, outst_o=4.
- hit_vd_i with the FIFO empty -> err_o[1]=1 and no mon_vd_o. Then clr_i -> err_o=0 and counters 0.
- Search with ready_i=4'b1011 -> err_o[2]=1. Hit with hit_tab_i=5 -> err_o[3]=1.
- Search, then no result for 64 cycles -> err_o[4]=1 at age 64. A later result reports lat>=64, lat_max_o updated.

Source files
------------

// File: rtl/search_mon_pkg.sv
// rtl/search_mon_pkg.sv - shared error indices, head-state type and saturating increment
package search_mon_pkg;

  localparam int ERR_OVF  = 0;
  localparam int ERR_SPUR = 1;
  localparam int ERR_NRDY = 2;
  localparam int ERR_TAB  = 3;
  localparam int ERR_TMO  = 4;
  localparam int ERR_W    = 5;

  typedef enum logic [1:0] {
    H_EMPTY = 2'd0,
    H_WAIT  = 2'd1,
    H_LATE  = 2'd2
  } h_state_t;

  // Increment a w-bit counter carried in 64 bits, holding at its all-ones value.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned w);
    logic [63:0] w_max;
    w_max = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (val == w_max) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/search_mon_fifo.sv
// rtl/search_mon_fifo.sv - synchronous FIFO with count, head read-through and push/pop in one cycle
module search_mon_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign rdata_o = r_mem[r_rptr];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= wdata_i;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/search_monitor.sv
// rtl/search_monitor.sv - pairs search results with keys, measures latency, counts and flags protocol errors
module search_monitor
  import search_mon_pkg::*;
#(
  parameter int C_NUM_TABLE      = 4,
  parameter int C_RULE_WIDTH     = 24,
  parameter int C_MEM_DATA_WIDTH = 56,
  parameter int C_MEM_ADDR_WIDTH = 8,
  parameter int C_MAX_OUTST      = 4,
  parameter int C_TIMEOUT        = 64,
  parameter int C_CNT_WIDTH      = 32,
  parameter int C_LAT_WIDTH      = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rstn_i,
  input  logic                                   clr_i,
  input  logic                                   search_i,
  input  logic [C_RULE_WIDTH-1:0]                key_i,
  input  logic [C_NUM_TABLE-1:0]                 ready_i,
  input  logic [C_NUM_TABLE-1:0]                 busy_i,
  input  logic                                   hit_vd_i,
  input  logic                                   hit_i,
  input  logic [3:0]                             hit_tab_i,
  input  logic [C_MEM_ADDR_WIDTH-1:0]            hit_addr_i,
  input  logic [C_MEM_DATA_WIDTH-C_RULE_WIDTH-1:0] hit_data_i,
  output logic                                   mon_vd_o,
  output logic [C_RULE_WIDTH-1:0]                mon_key_o,
  output logic                                   mon_hit_o,
  output logic [3:0]                             mon_tab_o,
  output logic [C_LAT_WIDTH-1:0]                 mon_lat_o,
  output logic [C_LAT_WIDTH-1:0]                 lat_max_o,
  output logic [C_CNT_WIDTH-1:0]                 search_cnt_o,
  output logic [C_CNT_WIDTH-1:0]                 hit_cnt_o,
  output logic [C_CNT_WIDTH-1:0]                 miss_cnt_o,
  output logic [$clog2(C_MAX_OUTST):0]           outst_o,
  output logic [ERR_W-1:0]                       err_o
);

  localparam int                     LP_OUTW    = $clog2(C_MAX_OUTST) + 1;
  localparam int                     LP_FW      = C_RULE_WIDTH + C_LAT_WIDTH;
  localparam logic [C_LAT_WIDTH-1:0] LP_TIMEOUT = C_LAT_WIDTH'(C_TIMEOUT);
  localparam logic [4:0]             LP_NTAB    = 5'(C_NUM_TABLE);

  logic [C_LAT_WIDTH-1:0]  r_ts;
  logic [C_LAT_WIDTH-1:0]  w_head_ts;
  logic [C_LAT_WIDTH-1:0]  w_age;
  logic [C_RULE_WIDTH-1:0] w_head_key;
  logic [LP_FW-1:0]        w_head;
  logic [LP_OUTW-1:0]      w_count;
  logic [ERR_W-1:0]        w_err_new;
  logic                    w_full, w_empty, w_push, w_pop, w_tmo, w_last;
  logic                    w_unused;
  h_state_t                r_hstate;

  assign w_unused = ^{hit_addr_i, hit_data_i};

  // Full/empty are judged at the start of the cycle, so a pop never makes room for a same-cycle push.
  assign w_push = search_i && !w_full;
  assign w_pop  = hit_vd_i && !w_empty;
  assign {w_head_key, w_head_ts} = w_head;
  assign w_age   = r_ts - w_head_ts;
  assign w_tmo   = (r_hstate == H_WAIT) && !w_pop && (w_age >= LP_TIMEOUT);
  assign w_last  = (w_count == LP_OUTW'(1)) && !w_push;
  assign outst_o = w_count;

  search_mon_fifo #(
    .WIDTH(LP_FW),
    .DEPTH(C_MAX_OUTST)
  ) u_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push_i (w_push),
    .pop_i  (w_pop),
    .wdata_i({key_i, r_ts}),
    .rdata_o(w_head),
    .full_o (w_full),
    .empty_o(w_empty),
    .count_o(w_count)
  );

  always_comb begin
    w_err_new           = '0;
    w_err_new[ERR_OVF]  = search_i && w_full;
    w_err_new[ERR_SPUR] = hit_vd_i && w_empty;
    w_err_new[ERR_NRDY] = search_i && ((ready_i != '1) || (busy_i != '0));
    w_err_new[ERR_TAB]  = hit_vd_i && hit_i && ({1'b0, hit_tab_i} >= LP_NTAB);
    w_err_new[ERR_TMO]  = w_tmo;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_hstate <= H_EMPTY;
    end else begin
      unique case (r_hstate)
        H_EMPTY: if (w_push) r_hstate <= H_WAIT;
        H_WAIT, H_LATE: begin
          if (w_pop)      r_hstate <= w_last ? H_EMPTY : H_WAIT;
          else if (w_tmo) r_hstate <= H_LATE;
        end
        default: r_hstate <= H_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ts         <= '0;
      mon_vd_o     <= 1'b0;
      mon_key_o    <= '0;
      mon_hit_o    <= 1'b0;
      mon_tab_o    <= '0;
      mon_lat_o    <= '0;
      lat_max_o    <= '0;
      search_cnt_o <= '0;
      hit_cnt_o    <= '0;
      miss_cnt_o   <= '0;
      err_o        <= '0;
    end else begin
      r_ts     <= r_ts + 1'b1;
      mon_vd_o <= w_pop;
      if (w_pop) begin
        mon_key_o <= w_head_key;
        mon_hit_o <= hit_i;
        mon_tab_o <= hit_tab_i;
        mon_lat_o <= w_age;
      end
      // Clear beats same-cycle increments but not an error detected in that cycle.
      if (clr_i) begin
        lat_max_o    <= '0;
        search_cnt_o <= '0;
        hit_cnt_o    <= '0;
        miss_cnt_o   <= '0;
        err_o        <= w_err_new;
      end else begin
        err_o <= err_o | w_err_new;
        if (w_push)
          search_cnt_o <= C_CNT_WIDTH'(sat_inc(64'(search_cnt_o), C_CNT_WIDTH));
        if (w_pop && hit_i)
          hit_cnt_o <= C_CNT_WIDTH'(sat_inc(64'(hit_cnt_o), C_CNT_WIDTH));
        if (w_pop && !hit_i)
          miss_cnt_o <= C_CNT_WIDTH'(sat_inc(64'(miss_cnt_o), C_CNT_WIDTH));
        if (w_pop && (w_age > lat_max_o))
          lat_max_o <= w_age;
      end
    end
  end

endmodule
